// File: rtl/fp_mul_sequencer.sv
// Operand-issue / result-collection stage in front of the FP multiplier.
// Buffers operand pairs, bypasses zero/special operands and guards against a hung multiplier.
module fp_mul_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_op1,
  input  logic [31:0]            in_op2,
  output logic [31:0]            op1,
  output logic [31:0]            op2,
  output logic                   mul_start,
  output logic                   mul_serv,
  input  logic [31:0]            mul_result,
  input  logic                   mul_done,
  input  logic                   mul_busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_pair_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SERV  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  op_pair_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [31:0]          op1_q, op1_d;
  logic [31:0]          op2_q, op2_d;
  logic [31:0]          out_result_q, out_result_d;
  logic                 out_err_q, out_err_d;
  logic                 mul_start_q, mul_start_d;
  logic                 mul_serv_q, mul_serv_d;
  logic                 out_valid_q, out_valid_d;

  logic                 push_c;
  logic                 pop_c;
  logic                 in_ready_c;
  op_pair_t             head_c;
  logic                 head_special_c;
  logic                 head_zero_c;
  logic                 unused_busy;

  // mul_busy is status only; control relies on the start/done/serve handshake
  assign unused_busy = mul_busy;

  assign in_ready_c     = (count_q != CNT_W'(DEPTH));
  assign push_c         = in_valid && in_ready_c;
  assign pop_c          = (state_q == IDLE) && (count_q != '0);
  assign head_c         = mem[rd_ptr_q];
  assign head_special_c = (head_c.a[30:23] == 8'hFF) || (head_c.b[30:23] == 8'hFF);
  assign head_zero_c    = (head_c.a[30:23] == 8'h00) || (head_c.b[30:23] == 8'h00);

  // Operand storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= op_pair_t'({in_op1, in_op2});
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (pop_c) begin
          op1_d = head_c.a;
          op2_d = head_c.b;
          if (head_special_c) begin
            out_result_d = QNAN;
            out_err_d    = 1'b1;
            state_d      = HOLD;
          end else if (head_zero_c) begin
            out_result_d = {head_c.a[31] ^ head_c.b[31], 31'b0};
            out_err_d    = 1'b0;
            state_d      = HOLD;
          end else begin
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done in the same cycle as expiry still wins
        if (mul_done) begin
          out_result_d = mul_result;
          out_err_d    = 1'b0;
          state_d      = SERV;
        end else if (timer_q == TIMER_W'(TIMEOUT)) begin
          out_result_d = QNAN;
          out_err_d    = 1'b1;
          state_d      = HOLD;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      SERV: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mul_start_d = (state_d == ISSUE);
    mul_serv_d  = (state_d == SERV);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      timer_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_serv_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      mul_start_q  <= mul_start_d;
      mul_serv_q   <= mul_serv_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign count      = count_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign mul_start  = mul_start_q;
  assign mul_serv   = mul_serv_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed self-checking bench for fp_mul_sequencer with a simple multiplier model.
module tb_fp_mul_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        mul_start;
  logic        mul_serv;
  logic [31:0] mul_result;
  logic        mul_done;
  logic        mul_busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic [2:0]  count;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_cnt    = 0;
  int serv_cnt     = 0;
  int overlap_cnt  = 0;
  logic xor_mode;

  fp_mul_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
    .op1(op1), .op2(op2), .mul_start(mul_start), .mul_serv(mul_serv),
    .mul_result(mul_result), .mul_done(mul_done), .mul_busy(mul_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .count(count)
  );

  always #5 clk = ~clk;

  // Multiplier model: fixed product, or a per-pair tag for ordering checks
  assign mul_result = xor_mode ? (op1 ^ op2) : 32'h4040_0000;

  always @(negedge clk) begin
    if (mul_start) start_cnt++;
    if (mul_serv) serv_cnt++;
    if (mul_start && mul_serv) overlap_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_op1   = a;
    in_op2   = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("push_stuck", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      step();
      cyc++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s0, v0, k;
    logic acc;
    logic [31:0] pa [6];
    logic [31:0] pb [6];
    logic [31:0] pexp [6];

    n_rst = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
    out_ready = 1'b0; mul_done = 1'b0; mul_busy = 1'b0; xor_mode = 1'b0;

    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_op1", op1, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Basic multiply, cycle-by-cycle handshake
    mul_done = 1'b1; mul_busy = 1'b1;
    s0 = start_cnt; v0 = serv_cnt;
    push_one(32'h3FC0_0000, 32'h4000_0000);
    check("basic_count", 32'(count), 32'd1);
    step();
    check("basic_start_e1", 32'(mul_start), 32'd1);
    check("basic_op1", op1, 32'h3FC0_0000);
    check("basic_op2", op2, 32'h4000_0000);
    step();
    check("basic_start_e2", 32'(mul_start), 32'd0);
    step();
    check("basic_serv_e3", 32'(mul_serv), 32'd1);
    step();
    check("basic_valid_e4", 32'(out_valid), 32'd1);
    check("basic_result", out_result, 32'h4040_0000);
    check("basic_err", 32'(out_err), 32'd0);
    check("basic_serv_e4", 32'(mul_serv), 32'd0);
    check("basic_starts", 32'(start_cnt - s0), 32'd1);
    check("basic_servs", 32'(serv_cnt - v0), 32'd1);
    drain();
    check("basic_valid_drop", 32'(out_valid), 32'd0);
    mul_busy = 1'b0;

    // Zero bypass
    s0 = start_cnt; v0 = serv_cnt;
    push_one(32'h8000_0000, 32'h3F80_0000);
    wait_valid(c);
    check("zero_latency", 32'(c), 32'd1);
    check("zero_result", out_result, 32'h8000_0000);
    check("zero_err", 32'(out_err), 32'd0);
    check("zero_no_start", 32'(start_cnt - s0), 32'd0);
    drain();

    // Special bypass
    push_one(32'h7F80_0000, 32'h3F80_0000);
    wait_valid(c);
    check("spec_latency", 32'(c), 32'd1);
    check("spec_result", out_result, 32'h7FC0_0000);
    check("spec_err", 32'(out_err), 32'd1);
    check("spec_no_start", 32'(start_cnt - s0), 32'd0);
    check("spec_no_serv", 32'(serv_cnt - v0), 32'd0);
    drain();

    // Full FIFO / backpressure with pointer wrap
    xor_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pa[i]   = 32'h3F80_0000 + 32'(i);
      pb[i]   = 32'h4000_0010 + 32'(i << 4);
      pexp[i] = pa[i] ^ pb[i];
    end
    for (int i = 0; i < 5; i++) begin
      in_op1 = pa[i]; in_op2 = pb[i]; in_valid = 1'b1;
      step();
    end
    in_op1 = pa[5]; in_op2 = pb[5];
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step(); step(); step();
    check("bp_stall_count", 32'(count), 32'd4);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_res0", out_result, pexp[0]);
    out_ready = 1'b1;
    k = 1;
    for (int n = 0; n < 80 && k < 6; n++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
      if (out_valid) begin
        check($sformatf("bp_res%0d", k), out_result, pexp[k]);
        k++;
      end
    end
    check("bp_all_results", 32'(k), 32'd6);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_empty", 32'(count), 32'd0);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    xor_mode = 1'b0;

    // Timeout
    mul_done = 1'b0;
    s0 = start_cnt; v0 = serv_cnt;
    push_one(32'h3FC0_0000, 32'h4000_0000);
    wait_valid(c);
    check("to_latency", 32'(c), 32'(TIMEOUT + 3));
    check("to_result", out_result, 32'h7FC0_0000);
    check("to_err", 32'(out_err), 32'd1);
    check("to_start", 32'(start_cnt - s0), 32'd1);
    check("to_no_serv", 32'(serv_cnt - v0), 32'd0);
    drain();
    mul_done = 1'b1;
    push_one(32'h3FC0_0000, 32'h4000_0000);
    wait_valid(c);
    check("to_next_latency", 32'(c), 32'd4);
    check("to_next_result", out_result, 32'h4040_0000);
    check("to_next_err", 32'(out_err), 32'd0);
    drain();

    // Reset while waiting with two pairs queued
    mul_done = 1'b0;
    in_valid = 1'b1;
    in_op1 = 32'h3F80_0000; in_op2 = 32'h4000_0000; step();
    in_op1 = 32'h3F80_0001; in_op2 = 32'h4000_0000; step();
    in_op1 = 32'h3F80_0002; in_op2 = 32'h4000_0000; step();
    in_valid = 1'b0;
    check("rw_count_queued", 32'(count), 32'd2);
    v0 = serv_cnt;
    #2;
    n_rst = 1'b0;
    #1;
    check("rw_count", 32'(count), 32'd0);
    check("rw_out_valid", 32'(out_valid), 32'd0);
    check("rw_in_ready", 32'(in_ready), 32'd1);
    check("rw_mul_start", 32'(mul_start), 32'd0);
    check("rw_mul_serv", 32'(mul_serv), 32'd0);
    check("rw_op1", op1, 32'd0);
    check("rw_op2", op2, 32'd0);
    check("rw_out_result", out_result, 32'd0);
    check("rw_out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    mul_done = 1'b1;
    check("rw_no_serv", 32'(serv_cnt - v0), 32'd0);
    push_one(32'h3FC0_0000, 32'h4000_0000);
    wait_valid(c);
    check("rw_after_latency", 32'(c), 32'd4);
    check("rw_after_result", out_result, 32'h4040_0000);
    drain();

    check("start_serv_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
